// File: rtl/ir_nec_rx.sv
// rtl/ir_nec_rx.sv - NEC infrared frame receiver with glitch filter and repeat-code window
// Decodes leader, 32 data bits and stop mark from a filtered IR demodulator line.
module ir_nec_rx #(
  parameter int UNIT_CYCLES      = 56000,
  parameter int ACTIVE_LOW       = 1,
  parameter int GLITCH_CYCLES    = 8,
  parameter int EXTENDED         = 0,
  parameter int REPEAT_WIN_UNITS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rcv,
  output logic [31:0] burst,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        ready,
  output logic        rpt,
  output logic        err
);

  localparam int LEN_MAX_C = 20 * UNIT_CYCLES;
  localparam int LEN_W     = $clog2(LEN_MAX_C + 1);
  localparam int GW        = $clog2(GLITCH_CYCLES + 1);
  localparam int UW        = $clog2(UNIT_CYCLES + 1);
  localparam int WW        = $clog2(REPEAT_WIN_UNITS + 1);

  typedef logic [LEN_W-1:0] len_t;

  localparam len_t SHORT_MIN = len_t'((3 * UNIT_CYCLES) / 4);
  localparam len_t SHORT_MAX = len_t'((5 * UNIT_CYCLES) / 4);
  localparam len_t ONE_MIN   = len_t'((9 * UNIT_CYCLES) / 4);
  localparam len_t ONE_MAX   = len_t'((15 * UNIT_CYCLES) / 4);
  localparam len_t RPT_MIN   = len_t'(3 * UNIT_CYCLES);
  localparam len_t RPT_MAX   = len_t'(5 * UNIT_CYCLES);
  localparam len_t HDR_MIN   = len_t'(6 * UNIT_CYCLES);
  localparam len_t HDR_MAX   = len_t'(10 * UNIT_CYCLES);
  localparam len_t LEAD_MIN  = len_t'(12 * UNIT_CYCLES);
  localparam len_t LEN_MAX   = len_t'(LEN_MAX_C);
  localparam len_t BIT_TMO   = len_t'(5 * UNIT_CYCLES);

  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic EXT      = (EXTENDED != 0);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_STOP_MARK  = 3'd5;
  localparam logic [2:0] S_RPT_STOP   = 3'd6;

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  len_t          len_q, len_d;
  logic [2:0]    state_q, state_d;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    bcnt_q, bcnt_d;
  logic [31:0]   burst_q, burst_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          ready_q, ready_d, rpt_q, rpt_d, err_q, err_d;
  logic [WW-1:0] win_q, win_d;
  logic [UW-1:0] ucnt_q, ucnt_d;

  logic mark_s, flip, mark_start, mark_end;
  logic is_short, is_one, is_rpt, is_hdr, is_lead, frame_ok;

  // Filtered level is 1 during a carrier mark regardless of line polarity.
  always_comb begin
    sync_d = {sync_q[0], rcv};
    mark_s = sync_q[1] ^ IDLE_LVL;
    flip   = 1'b0;
    filt_d = filt_q;
    gcnt_d = '0;
    if (mark_s != filt_q) begin
      if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
        flip   = 1'b1;
        filt_d = mark_s;
      end else begin
        gcnt_d = gcnt_q + GW'(1);
      end
    end
    mark_start = flip & ~filt_q;
    mark_end   = flip & filt_q;
    if (flip)                len_d = '0;
    else if (len_q == LEN_MAX) len_d = len_q;
    else                     len_d = len_q + len_t'(1);
  end

  always_comb begin
    is_short = (len_q >= SHORT_MIN) && (len_q <= SHORT_MAX);
    is_one   = (len_q >= ONE_MIN)   && (len_q <= ONE_MAX);
    is_rpt   = (len_q >= RPT_MIN)   && (len_q <= RPT_MAX);
    is_hdr   = (len_q >= HDR_MIN)   && (len_q <= HDR_MAX);
    is_lead  = (len_q >= LEAD_MIN)  && (len_q <= LEN_MAX);
    frame_ok = (sr_q[31:24] == ~sr_q[23:16]) && (EXT || (sr_q[15:8] == ~sr_q[7:0]));

    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    ready_d = 1'b0;
    rpt_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: if (mark_start) state_d = S_LEAD_MARK;
      S_LEAD_MARK: if (mark_end) begin
        if (is_lead) state_d = S_LEAD_SPACE;
        else begin err_d = 1'b1; state_d = S_IDLE; end
      end
      S_LEAD_SPACE: if (mark_start) begin
        if (is_hdr) begin
          state_d = S_BIT_MARK;
          bcnt_d  = '0;
        end else if (is_rpt) state_d = S_RPT_STOP;
        else begin err_d = 1'b1; state_d = S_IDLE; end
      end
      S_BIT_MARK: if (mark_end) begin
        if (is_short) state_d = S_BIT_SPACE;
        else begin err_d = 1'b1; state_d = S_IDLE; end
      end
      S_BIT_SPACE: begin
        // First bit received ends up in sr_q[0] after 32 right shifts.
        if (mark_start) begin
          if (is_short || is_one) begin
            sr_d    = {is_one, sr_q[31:1]};
            bcnt_d  = bcnt_q + 6'd1;
            state_d = (bcnt_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
          end else begin
            err_d = 1'b1; state_d = S_IDLE;
          end
        end else if (len_q >= BIT_TMO) begin
          err_d = 1'b1; state_d = S_IDLE;
        end
      end
      S_STOP_MARK: if (mark_end) begin
        if (is_short && frame_ok) begin
          ready_d = 1'b1;
          burst_d = sr_q;
          addr_d  = EXT ? sr_q[15:0] : {8'h00, sr_q[7:0]};
          cmd_d   = sr_q[23:16];
        end else err_d = 1'b1;
        state_d = S_IDLE;
      end
      S_RPT_STOP: if (mark_end) begin
        rpt_d   = is_short && (win_q != '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Repeat window counts down in whole units once opened by a ready or rpt.
  always_comb begin
    win_d  = win_q;
    ucnt_d = ucnt_q;
    if (ready_d || rpt_d) begin
      win_d  = WW'(REPEAT_WIN_UNITS);
      ucnt_d = '0;
    end else if (win_q != '0) begin
      if (ucnt_q == UW'(UNIT_CYCLES - 1)) begin
        ucnt_d = '0;
        win_d  = win_q - WW'(1);
      end else begin
        ucnt_d = ucnt_q + UW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {2{IDLE_LVL}};
      filt_q  <= 1'b0;
      gcnt_q  <= '0;
      len_q   <= '0;
      state_q <= S_IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      cmd_q   <= '0;
      ready_q <= 1'b0;
      rpt_q   <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= '0;
      ucnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      filt_q  <= filt_d;
      gcnt_q  <= gcnt_d;
      len_q   <= len_d;
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      ready_q <= ready_d;
      rpt_q   <= rpt_d;
      err_q   <= err_d;
      win_q   <= win_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign burst = burst_q;
  assign addr  = addr_q;
  assign cmd   = cmd_q;
  assign ready = ready_q;
  assign rpt   = rpt_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb/tb_ir_nec_rx.sv - directed and randomized NEC frames against a byte-level reference model
`timescale 1ns/1ps
module tb_ir_nec_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_line = 1'b1;
  logic        use_x = 1'b0;
  logic        rcv, rcv_x;
  logic [31:0] burst, burst_x;
  logic [15:0] addr, addr_x;
  logic [7:0]  cmd, cmd_x;
  logic        ready, rpt, err, ready_x, rpt_x, err_x;

  int checks = 0;
  int errors = 0;
  int n_ready = 0, n_rpt = 0, n_err = 0, n_multi = 0;
  int n_ready_x = 0, n_rpt_x = 0, n_err_x = 0, n_multi_x = 0;
  int r0, p0, e0;

  // reference model state
  logic [31:0] exp_burst = '0;
  logic [15:0] exp_addr  = '0;
  logic [7:0]  exp_cmd   = '0;
  bit          win_valid = 0;
  time         win_open_t = 0;
  localparam time WIN_NS = 200 * 560;

  assign rcv   = use_x ? 1'b1 : ir_line;
  assign rcv_x = use_x ? ir_line : 1'b1;

  always #5 clk = ~clk;

  ir_nec_rx #(.UNIT_CYCLES(56)) dut (
    .clk(clk), .rst(rst), .rcv(rcv), .burst(burst), .addr(addr), .cmd(cmd),
    .ready(ready), .rpt(rpt), .err(err)
  );

  ir_nec_rx #(.UNIT_CYCLES(56), .EXTENDED(1)) dut_x (
    .clk(clk), .rst(rst), .rcv(rcv_x), .burst(burst_x), .addr(addr_x), .cmd(cmd_x),
    .ready(ready_x), .rpt(rpt_x), .err(err_x)
  );

  always @(negedge clk) begin
    if (ready) n_ready++;
    if (rpt)   n_rpt++;
    if (err)   n_err++;
    if (int'(ready) + int'(rpt) + int'(err) > 1) n_multi++;
    if (ready_x) n_ready_x++;
    if (rpt_x)   n_rpt_x++;
    if (err_x)   n_err_x++;
    if (int'(ready_x) + int'(rpt_x) + int'(err_x) > 1) n_multi_x++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ok(input logic [31:0] f, input bit ext);
    logic [7:0] b0, b1, b2, b3;
    {b3, b2, b1, b0} = f;
    return ((b3 ^ b2) == 8'hFF) && (ext || ((b1 ^ b0) == 8'hFF));
  endfunction

  task automatic mark(input int ns);
    ir_line = 1'b0;
    #(ns);
  endtask

  task automatic space(input int ns);
    ir_line = 1'b1;
    #(ns);
  endtask

  task automatic send_bits(input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      mark(560);
      space(f[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input bit spikes);
    mark(9000);
    if (spikes) begin
      space(1000); mark(40); space(1500); mark(40); space(1920);
    end else begin
      space(4500);
    end
    send_bits(f, 32);
    mark(560);
    space(3000);
  endtask

  task automatic send_repeat();
    mark(9000);
    space(2250);
    mark(560);
    space(3000);
  endtask

  task automatic snap();
    r0 = n_ready; p0 = n_rpt; e0 = n_err;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #100;
    rst = 1'b1;
    #50;
    exp_burst = '0; exp_addr = '0; exp_cmd = '0;
    win_valid = 0;
  endtask

  // Advance the model for a decoded frame and compare every output.
  task automatic frame_and_check(input string tag, input logic [31:0] f, input bit spikes);
    bit ok;
    ok = model_ok(f, 1'b0);
    snap();
    send_frame(f, spikes);
    if (ok) begin
      exp_burst = f;
      exp_addr  = {8'h00, f[7:0]};
      exp_cmd   = f[23:16];
      win_valid = 1;
      win_open_t = $time;
    end
    chk({tag, "_ready"}, n_ready - r0, ok ? 1 : 0);
    chk({tag, "_err"},   n_err - e0,   ok ? 0 : 1);
    chk({tag, "_burst"}, burst, exp_burst);
    chk({tag, "_addr"},  addr,  exp_addr);
    chk({tag, "_cmd"},   cmd,   exp_cmd);
  endtask

  task automatic repeat_and_check(input string tag);
    bit open;
    open = win_valid && (($time - win_open_t) < WIN_NS - 20000);
    snap();
    send_repeat();
    if (open) win_open_t = $time;
    chk({tag, "_rpt"}, n_rpt - p0, open ? 1 : 0);
    chk({tag, "_err"}, n_err - e0, 0);
  endtask

  initial begin
    logic [31:0] f;
    logic [7:0]  a, c;
    int          mode;

    #2;
    do_reset();
    chk("rst_burst", burst, 0);
    chk("rst_addr",  addr,  0);
    chk("rst_cmd",   cmd,   0);
    chk("rst_pulses", {29'd0, ready, rpt, err}, 0);

    frame_and_check("basic", 32'h27D8EF10, 1'b0);
    chk("basic_burst_const", burst, 32'h27D8EF10);
    frame_and_check("badcmd", 32'h2FD8EF10, 1'b0);

    frame_and_check("pre_rpt", 32'h6699FE01, 1'b0);
    repeat_and_check("rpt_open");

    // reset in the middle of a frame
    snap();
    mark(9000); space(4500); send_bits(32'hA55AF00F, 5);
    ir_line = 1'b0;
    #200;
    do_reset();
    space(3000);
    chk("midrst_pulses", (n_ready - r0) + (n_rpt - p0) + (n_err - e0), 0);
    chk("midrst_burst", burst, 0);
    repeat_and_check("rpt_after_rst");

    frame_and_check("spikes", 32'hB54A7788, 1'b1);

    // truncated frame: line held idle after the 11th mark
    snap();
    mark(9000); space(4500); send_bits(32'h000003FF, 10); mark(560);
    ir_line = 1'b1;
    #2600;
    chk("trunc_early_err", n_err - e0, 0);
    #700;
    chk("trunc_err", n_err - e0, 1);
    chk("trunc_ready", n_ready - r0, 0);
    chk("trunc_burst", burst, exp_burst);
    space(1000);

    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom);
      c = 8'($urandom);
      mode = $urandom_range(0, 2);
      f = {~c, c, ~a, a};
      if (mode == 1) f[31:24] = f[31:24] ^ (8'h01 << $urandom_range(0, 7));
      if (mode == 2) f[15:8]  = f[15:8]  ^ (8'h01 << $urandom_range(0, 7));
      frame_and_check($sformatf("rand%0d", k), f, 1'b0);
    end

    // extended-address instance
    use_x = 1'b1;
    r0 = n_ready_x; e0 = n_err_x;
    send_frame(32'hAA551234, 1'b0);
    use_x = 1'b0;
    chk("ext_ready", n_ready_x - r0, 1);
    chk("ext_err",   n_err_x - e0,   0);
    chk("ext_addr",  addr_x,  16'h1234);
    chk("ext_cmd",   cmd_x,   8'h55);
    chk("ext_burst", burst_x, 32'hAA551234);

    chk("exclusive", n_multi, 0);
    chk("exclusive_x", n_multi_x, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
